// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the banked data memory.
//   state_t   : controller states (array clear, idle, response held)
//   BYTE_W    : width of one bank lane
//   row_carry : bank-to-row mapping helper for interleaved accesses
package dmem_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Byte b of the array lives in bank b%NB, row b/NB. An access starting in
  // lane `lane` of row r places its bytes in banks lane..NB-1 of row r and
  // wraps into banks 0..lane-1 of row r+1. Returns 1 when `bank` takes r+1.
  function automatic logic row_carry(input int unsigned bank, input int unsigned lane);
    return (bank < lane);
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: one byte-wide bank of the data memory.
//   clock : rising-edge clock
//   we    : write enable for this bank
//   row   : row index (shared by read and write)
//   wdata : byte to write
//   rdata : combinational read of the addressed row
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int ROWS = 32,
  parameter int RW   = 5
) (
  input  logic              clock,
  input  logic              we,
  input  logic [RW-1:0]     row,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [ROWS];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[row] <= wdata;
    end
  end

  assign rdata = mem[row];

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable, big-endian data memory with a valid/ready
// request port and a held response port. NB interleaved byte banks let any
// access, aligned or not, complete in one array cycle.
//   clock, reset           : clock and asynchronous active-high reset
//   req_valid/req_ready    : request handshake
//   req_we/addr/wdata/be   : write flag, first byte address, data, byte enables
//   rsp_valid/rsp_ready    : response handshake (response held until taken)
//   rsp_rdata/rsp_err      : read data (0 for writes/errors), access rejected
//   busy                   : post-reset array clear in progress
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int MEM_BYTES      = 64,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [DATA_W/8-1:0]    req_be,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int ROWS  = MEM_BYTES / NB;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SHIFT = $clog2(NB);
  localparam int LNB   = (NB > 1) ? SHIFT : 1;

  state_t            state;
  logic [RW-1:0]     clear_row;
  logic              accept;
  logic              range_err;
  logic              align_err;
  logic              acc_err;
  logic [ADDR_W:0]   end_addr;
  logic [LNB-1:0]    lane;
  logic [RW-1:0]     row_base;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] rsp_data_next;

  logic [BYTE_W-1:0] wbyte      [NB];
  logic              wbe        [NB];
  logic [BYTE_W-1:0] bank_rdata [NB];

  assign busy      = (state == CLEAR);
  assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;

  // One extra bit so an address near the top of the address space cannot wrap
  // back into range.
  assign end_addr  = {1'b0, req_addr} + (ADDR_W+1)'(NB - 1);
  assign range_err = (32'(end_addr) >= 32'(MEM_BYTES));
  assign lane      = (NB > 1) ? LNB'(req_addr) : '0;
  assign align_err = (ALLOW_MISALIGN == 0) && (lane != '0);
  assign acc_err   = range_err || align_err;
  assign row_base  = RW'(req_addr >> SHIFT);

  // Byte k of the access: index 0 is the most significant byte (big-endian).
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign wbyte[gi] = req_wdata[DATA_W-1-BYTE_W*gi -: BYTE_W];
    assign wbe[gi]   = req_be[NB-1-gi];
    // Unrotate: access byte gi came from bank (lane + gi) mod NB.
    assign rd_data[DATA_W-1-BYTE_W*gi -: BYTE_W] = bank_rdata[LNB'(gi) + lane];
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_bank
    logic [LNB-1:0]    k_idx;
    logic [RW-1:0]     row;
    logic              we;
    logic [BYTE_W-1:0] wdata;

    // Rotate: bank gi holds access byte (gi - lane) mod NB.
    assign k_idx = LNB'(gi) - lane;
    assign row   = busy ? clear_row
                        : row_base + RW'(row_carry(gi, 32'(lane)));
    assign we    = busy || (accept && !acc_err && req_we && wbe[k_idx]);
    assign wdata = busy ? '0 : wbyte[k_idx];

    dmem_bank #(
      .ROWS (ROWS),
      .RW   (RW)
    ) u_bank (
      .clock (clock),
      .we    (we),
      .row   (row),
      .wdata (wdata),
      .rdata (bank_rdata[gi])
    );
  end

  assign rsp_data_next = (acc_err || req_we) ? '0 : rd_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      clear_row <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clear_row == RW'(ROWS - 1)) begin
            state <= IDLE;
          end else begin
            clear_row <= clear_row + 1'b1;
          end
        end
        IDLE, RESP: begin
          if (accept) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_rdata <= rsp_data_next;
          end else if ((state == RESP) && rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed plus randomized checks of data_mem_ctrl against a
// byte-array reference model. Instance 0 uses defaults; instance 1 rejects
// misaligned accesses.
module tb_data_mem_ctrl;

  localparam int NB        = 2;
  localparam int MEM_BYTES = 64;

  logic        clk;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic [1:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [15:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  logic [7:0]  mem_model [2][MEM_BYTES];

  int checks = 0;
  int errors = 0;

  data_mem_ctrl dut (
    .clock(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  data_mem_ctrl #(.ALLOW_MISALIGN(0)) dut_na (
    .clock(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model(input int sel);
    for (int i = 0; i < MEM_BYTES; i++) mem_model[sel][i] = 8'h00;
  endtask

  // Reference: bytes addr..addr+NB-1, first byte is the most significant.
  task automatic model_access(input int sel, input bit we, input int addr,
                              input logic [15:0] wd, input logic [1:0] be,
                              output logic [15:0] rd, output logic err);
    rd  = '0;
    err = 1'b0;
    if ((addr + NB - 1 >= MEM_BYTES) || (sel == 1 && (addr % NB) != 0)) begin
      err = 1'b1;
      return;
    end
    for (int k = 0; k < NB; k++) begin
      if (we) begin
        if (be[NB-1-k]) mem_model[sel][addr+k] = wd[15-8*k -: 8];
      end else begin
        rd[15-8*k -: 8] = mem_model[sel][addr+k];
      end
    end
  endtask

  // Count cycles until req_ready rises after a reset release.
  task automatic wait_clear(input int sel, input string tag);
    int n;
    n = 0;
    while (req_ready[sel] !== 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    chk({tag, "_cycles"}, 32'(n), 32);
    chk({tag, "_busy_low"}, 32'(busy[sel]), 0);
  endtask

  // One request, checked response, random response back-pressure, then idle.
  task automatic access(input int sel, input bit we, input int addr,
                        input logic [15:0] wd, input logic [1:0] be,
                        input string tag, output logic [15:0] got);
    logic [15:0] erd;
    logic        eerr;
    int          n;
    int          hold;
    req_valid[sel] = 1'b1;
    req_we[sel]    = we;
    req_addr[sel]  = 16'(addr);
    req_wdata[sel] = wd;
    req_be[sel]    = be;
    rsp_ready[sel] = 1'b1;
    n = 0;
    while (req_ready[sel] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_req_ready"}, 32'(req_ready[sel]), 1);
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
    model_access(sel, we, addr, wd, be, erd, eerr);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid[sel]), 1);
    chk({tag, "_rdata"}, 32'(rsp_rdata[sel]), 32'(erd));
    chk({tag, "_err"}, 32'(rsp_err[sel]), 32'(eerr));
    got = rsp_rdata[sel];
    hold = $urandom_range(0, 2);
    rsp_ready[sel] = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(rsp_valid[sel]), 1);
      chk({tag, "_hold_rdata"}, 32'(rsp_rdata[sel]), 32'(erd));
      chk({tag, "_hold_ready"}, 32'(req_ready[sel]), 0);
    end
    rsp_ready[sel] = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_drain"}, 32'(rsp_valid[sel]), 0);
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] erd;
    logic        eerr;
    int          addr;

    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0;
      req_wdata[s] = '0;   req_be[s] = '0;   rsp_ready[s] = 1'b0;
      clear_model(s);
    end

    // Reset state and clear duration
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy[0]), 1);
    chk("rst_req_ready", 32'(req_ready[0]), 0);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 0);
    chk("rst_rdata", 32'(rsp_rdata[0]), 0);
    chk("rst_err", 32'(rsp_err[0]), 0);
    reset = 1'b0;
    wait_clear(0, "clear0");

    // Directed accesses
    access(0, 0, 10, 16'h0, 2'b00, "rd10", got);
    chk("rd10_const", 32'(got), 32'h0000);
    access(0, 1, 4, 16'hABCD, 2'b11, "wr4", got);
    access(0, 0, 4, 16'h0, 2'b00, "rd4", got);
    chk("rd4_const", 32'(got), 32'hABCD);
    access(0, 0, 5, 16'h0, 2'b00, "rd5_cross", got);
    chk("rd5_const", 32'(got), 32'hCD00);
    access(0, 1, 4, 16'h1234, 2'b01, "wr4_be01", got);
    access(0, 0, 4, 16'h0, 2'b00, "rd4_be01", got);
    chk("rd4_be01_const", 32'(got), 32'hAB34);
    access(0, 1, 7, 16'h5566, 2'b11, "wr7_mis", got);
    access(0, 0, 6, 16'h0, 2'b00, "rd6", got);
    chk("rd6_const", 32'(got), 32'h0055);
    access(0, 0, 8, 16'h0, 2'b00, "rd8", got);
    chk("rd8_const", 32'(got), 32'h6600);
    access(0, 1, 20, 16'hFFFF, 2'b00, "wr20_be0", got);
    access(0, 0, 20, 16'h0, 2'b00, "rd20_be0", got);

    // Range boundaries
    access(0, 0, 63, 16'h0, 2'b00, "rd63_oor", got);
    access(0, 1, 63, 16'hBEEF, 2'b11, "wr63_oor", got);
    access(0, 0, 62, 16'h0, 2'b00, "rd62", got);
    chk("rd62_const", 32'(got), 32'h0000);
    access(0, 0, 16'hFFFF, 16'h0, 2'b00, "rd_ffff", got);
    access(0, 1, 16'hFFFF, 16'h1111, 2'b11, "wr_ffff", got);

    // Back-to-back reads, one response per cycle
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    erd = '0;
    for (int i = 0; i < 4; i++) begin
      addr = 4 + i;
      req_addr[0] = 16'(addr);
      @(posedge clk); #1;
      model_access(0, 0, addr, 16'h0, 2'b00, erd, eerr);
      chk("b2b_valid", 32'(rsp_valid[0]), 1);
      chk("b2b_rdata", 32'(rsp_rdata[0]), 32'(erd));
      chk("b2b_req_ready", 32'(req_ready[0]), 1);
    end
    // Stall with a pending request
    req_addr[0]  = 16'd8;
    rsp_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(rsp_valid[0]), 1);
      chk("stall_rdata", 32'(rsp_rdata[0]), 32'(erd));
      chk("stall_req_ready", 32'(req_ready[0]), 0);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    model_access(0, 0, 8, 16'h0, 2'b00, erd, eerr);
    chk("unstall_valid", 32'(rsp_valid[0]), 1);
    chk("unstall_rdata", 32'(rsp_rdata[0]), 32'(erd));
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("unstall_idle", 32'(rsp_valid[0]), 0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) addr = $urandom_range(60, 65535);
      else addr = $urandom_range(0, 63);
      access(0, 1'($urandom_range(0, 1)), addr, 16'($urandom),
             2'($urandom_range(0, 3)), "rand", got);
    end

    // Alignment-checking instance
    access(1, 0, 5, 16'h0, 2'b00, "na_rd5", got);
    access(1, 1, 4, 16'h1357, 2'b11, "na_wr4", got);
    access(1, 1, 5, 16'hFFFF, 2'b11, "na_wr5", got);
    access(1, 0, 4, 16'h0, 2'b00, "na_rd4", got);
    chk("na_rd4_const", 32'(got), 32'h1357);

    // Reset while a response is pending
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 16'd4;
    rsp_ready[1] = 1'b0;
    @(posedge clk); #1;
    chk("mid_rsp_valid", 32'(rsp_valid[1]), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid[1]), 0);
    chk("mid_rst_busy", 32'(busy[1]), 1);
    chk("mid_rst_ready", 32'(req_ready[1]), 0);
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_model(0);
    clear_model(1);
    wait_clear(1, "clear1");
    access(1, 0, 4, 16'h0, 2'b00, "na_rd4_after", got);
    access(0, 0, 4, 16'h0, 2'b00, "rd4_after", got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
